e_mdu: RTL and testbench

- Multiply/divide unit for the E stage, alongside the ALU.
- Owns the HI/LO registers and sequences multi-cycle mult/div operations.
- Exposes a busy indication so the hazard unit can stall the D stage.
- Serves mfhi/mflo reads and mthi/mtlo writes.

---
 rtl/e_mdu.sv | 135 +++++++++++++
 tb/tb_e_mdu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit owning HI/LO, with busy for D-stage stall.
// Define MDU_MADD_EN to enable madd/maddu (ops 9/10) accumulating into {HI,LO}.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] MDU_a,
   input  logic [31:0] MDU_b,
   input  logic [3:0]  CU_MDU_op,
   input  logic        MDU_start,
   output logic        MDU_busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] E_MDU_out
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
   localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          commit;
   logic [31:0]   p_hi, p_lo;
   logic          p_wr;

   logic          is_mul, is_div, is_madd, is_sgn, go;
   logic [63:0]   ext_a, ext_b, prod, res;
   logic          neg_a, neg_b;
   logic [31:0]   mag_a, mag_b, dvs, uq, ur, quo, rem;

   always_comb begin
      is_mul  = (CU_MDU_op == 4'd1) || (CU_MDU_op == 4'd2);
      is_div  = (CU_MDU_op == 4'd3) || (CU_MDU_op == 4'd4);
`ifdef MDU_MADD_EN
      is_madd = (CU_MDU_op == 4'd9) || (CU_MDU_op == 4'd10);
`else
      is_madd = 1'b0;
`endif
      is_sgn  = (CU_MDU_op == 4'd1) || (CU_MDU_op == 4'd3) ||
                (CU_MDU_op == 4'd9);
      go      = MDU_start && (is_mul || is_div || is_madd);
   end

   // Low 64 bits of the product are correct once operands are extended.
   always_comb begin
      ext_a = is_sgn ? {{32{MDU_a[31]}}, MDU_a} : {32'd0, MDU_a};
      ext_b = is_sgn ? {{32{MDU_b[31]}}, MDU_b} : {32'd0, MDU_b};
      prod  = ext_a * ext_b;
   end

   // One unsigned divider on magnitudes; signs are restored afterwards.
   always_comb begin
      neg_a = is_sgn && MDU_a[31];
      neg_b = is_sgn && MDU_b[31];
      mag_a = neg_a ? -MDU_a : MDU_a;
      mag_b = neg_b ? -MDU_b : MDU_b;
      dvs   = (mag_b == 32'd0) ? 32'd1 : mag_b;
      uq    = mag_a / dvs;
      ur    = mag_a % dvs;
      quo   = (neg_a ^ neg_b) ? -uq : uq;
      rem   = neg_a ? -ur : ur;
   end

   always_comb begin
      res = prod;
      if (is_div) res = {rem, quo};
`ifdef MDU_MADD_EN
      if (is_madd) res = {HI, LO} + prod;
`endif
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      commit    = 1'b0;
      unique case (state)
         IDLE: begin
            if (go) begin
               state_nxt = RUN;
               cnt_nxt   = is_div ? DIV_LD : MULT_LD;
            end
         end
         RUN: begin
            if (cnt == '0) begin
               commit    = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         MDU_busy <= 1'b0;
         HI       <= '0;
         LO       <= '0;
         p_hi     <= '0;
         p_lo     <= '0;
         p_wr     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         MDU_busy <= (state_nxt == RUN);
         if (state == IDLE && go) begin
            {p_hi, p_lo} <= res;
            p_wr         <= !(is_div && MDU_b == 32'd0);
         end
         if (commit) begin
            if (p_wr) {HI, LO} <= {p_hi, p_lo};
         end else if (state == IDLE) begin
            if (CU_MDU_op == 4'd7) HI <= MDU_a;
            if (CU_MDU_op == 4'd8) LO <= MDU_a;
         end
      end
   end

   always_comb begin
      E_MDU_out = '0;
      if (CU_MDU_op == 4'd5) E_MDU_out = HI;
      if (CU_MDU_op == 4'd6) E_MDU_out = LO;
   end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: vector table, hand sequences and random ops vs an arithmetic model.
// Honours MDU_MADD_EN the same way the design does.
module tb_e_mdu;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] MDU_a, MDU_b;
   logic [3:0]  CU_MDU_op;
   logic        MDU_start;
   logic        MDU_busy;
   logic [31:0] HI, LO, E_MDU_out;

   int vecs = 0;
   int errs = 0;
   logic [31:0] m_hi, m_lo;

   e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .MDU_a(MDU_a), .MDU_b(MDU_b),
      .CU_MDU_op(CU_MDU_op), .MDU_start(MDU_start),
      .MDU_busy(MDU_busy), .HI(HI), .LO(LO), .E_MDU_out(E_MDU_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [3:0]  op;
      logic [31:0] a, b;
      int          n;
      logic [31:0] hi, lo;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Reference: plain arithmetic on the architectural HI/LO.
   function automatic int model(input logic [3:0] op,
                                input logic [31:0] a, b);
      longint      sp;
      logic [63:0] up;
      int          sa, sb;
      sa = a;
      sb = b;
      case (op)
         4'd1: begin
            sp = longint'(sa) * longint'(sb);
            {m_hi, m_lo} = sp;
            return MC;
         end
         4'd2: begin
            up = {32'd0, a} * {32'd0, b};
            {m_hi, m_lo} = up;
            return MC;
         end
         4'd3: begin
            if (b == 0) return DC;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               m_lo = 32'h8000_0000;
               m_hi = 32'd0;
            end else begin
               m_lo = sa / sb;
               m_hi = sa % sb;
            end
            return DC;
         end
         4'd4: begin
            if (b == 0) return DC;
            m_lo = a / b;
            m_hi = a % b;
            return DC;
         end
         4'd7: begin m_hi = a; return 0; end
         4'd8: begin m_lo = a; return 0; end
`ifdef MDU_MADD_EN
         4'd9: begin
            sp = longint'(sa) * longint'(sb);
            {m_hi, m_lo} = {m_hi, m_lo} + sp;
            return MC;
         end
         4'd10: begin
            up = {32'd0, a} * {32'd0, b};
            {m_hi, m_lo} = {m_hi, m_lo} + up;
            return MC;
         end
`endif
         default: return 0;
      endcase
   endfunction

   task automatic do_vec(input string nm, input logic [3:0] op,
                         input logic [31:0] a, b, input int en,
                         input logic [31:0] eh, el);
      int n = 0;
      @(negedge clk);
      CU_MDU_op = op; MDU_a = a; MDU_b = b; MDU_start = 1'b1;
      @(posedge clk);
      #1;
      MDU_start = 1'b0; CU_MDU_op = 4'd0;
      while (n < 40) begin
         @(negedge clk);
         if (!MDU_busy) break;
         n++;
      end
      chk({nm, " busy_len"}, n, en);
      chk({nm, " HI"}, HI, eh);
      chk({nm, " LO"}, LO, el);
      CU_MDU_op = 4'd5;
      #1 chk({nm, " mfhi"}, E_MDU_out, eh);
      CU_MDU_op = 4'd6;
      #1 chk({nm, " mflo"}, E_MDU_out, el);
      CU_MDU_op = 4'd0;
      #1 chk({nm, " out_none"}, E_MDU_out, 32'd0);
   endtask

   initial begin
      tbl[0]  = '{"mult", 1, 32'hFFFF_FFFE, 3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
      tbl[1]  = '{"divu", 4, 7, 2, DC, 1, 3};
      tbl[2]  = '{"div_neg", 3, 32'hFFFF_FFF9, 2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      tbl[3]  = '{"mthi", 7, 32'h1234_5678, 0, 0, 32'h1234_5678, 32'hFFFF_FFFD};
      tbl[4]  = '{"mtlo", 8, 32'h9ABC_DEF0, 0, 0, 32'h1234_5678, 32'h9ABC_DEF0};
      tbl[5]  = '{"mthi2", 7, 32'h11, 0, 0, 32'h11, 32'h9ABC_DEF0};
      tbl[6]  = '{"mtlo2", 8, 32'h22, 0, 0, 32'h11, 32'h22};
      tbl[7]  = '{"div0", 3, 5, 0, DC, 32'h11, 32'h22};
      tbl[8]  = '{"divu0", 4, 5, 0, DC, 32'h11, 32'h22};
      tbl[9]  = '{"op_none", 0, 1, 1, 0, 32'h11, 32'h22};
      tbl[10] = '{"op_mfhi", 5, 1, 1, 0, 32'h11, 32'h22};
      tbl[11] = '{"div_ovf", 3, 32'h8000_0000, 32'hFFFF_FFFF, DC, 0, 32'h8000_0000};
      tbl[12] = '{"multu_max", 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 32'hFFFF_FFFE, 1};
      tbl[13] = '{"div_negb", 3, 7, 32'hFFFF_FFFE, DC, 1, 32'hFFFF_FFFD};
      tbl[14] = '{"mult_min", 1, 32'h8000_0000, 32'h8000_0000, MC, 32'h4000_0000, 0};
`ifdef MDU_MADD_EN
      tbl[15] = '{"madd", 9, 2, 3, MC, 32'h4000_0000, 6};
`else
      tbl[15] = '{"madd_off", 9, 2, 3, 0, 32'h4000_0000, 0};
`endif

      reset = 1'b1; MDU_a = '0; MDU_b = '0;
      CU_MDU_op = '0; MDU_start = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst busy", {31'd0, MDU_busy}, 32'd0);
      chk("rst HI", HI, 32'd0);
      chk("rst LO", LO, 32'd0);

      foreach (tbl[i])
         do_vec(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b,
                tbl[i].n, tbl[i].hi, tbl[i].lo);

      // Second start while busy must not restart or disturb the op.
      begin
         int n = 0;
         @(negedge clk);
         CU_MDU_op = 4'd4; MDU_a = 100; MDU_b = 7; MDU_start = 1'b1;
         @(posedge clk);
         #1 MDU_start = 1'b0; CU_MDU_op = 4'd0;
         while (n < 40) begin
            @(negedge clk);
            if (!MDU_busy) break;
            n++;
            if (n == 3) begin
               CU_MDU_op = 4'd1; MDU_a = 3; MDU_b = 3; MDU_start = 1'b1;
            end else begin
               CU_MDU_op = 4'd0; MDU_start = 1'b0;
            end
         end
         MDU_start = 1'b0; CU_MDU_op = 4'd0;
         chk("restart busy_len", n, DC);
         chk("restart HI", HI, 32'd2);
         chk("restart LO", LO, 32'd14);
      end

      do_vec("madd_hi0", 7, 0, 0, 0, 0, 14);
      do_vec("madd_lo", 8, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
      do_vec("maddu", 10, 1, 1, MC, 1, 0);
`else
      do_vec("maddu_off", 10, 1, 1, 0, 0, 32'hFFFF_FFFF);
`endif

      // Reset on the third busy cycle aborts the multiply.
      @(negedge clk);
      CU_MDU_op = 4'd2; MDU_a = '1; MDU_b = '1; MDU_start = 1'b1;
      @(posedge clk);
      #1 MDU_start = 1'b0; CU_MDU_op = 4'd0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("abort busy", {31'd0, MDU_busy}, 32'd0);
      chk("abort HI", HI, 32'd0);
      chk("abort LO", LO, 32'd0);
      repeat (12) @(negedge clk);
      chk("abort late busy", {31'd0, MDU_busy}, 32'd0);
      chk("abort late HI", HI, 32'd0);
      chk("abort late LO", LO, 32'd0);

      m_hi = 0;
      m_lo = 0;
      begin
         logic [3:0] ops[8];
         ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10};
         for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            int          en;
            op = ops[$urandom_range(0, 7)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
               0: b = 0;
               1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
               2: b = $urandom_range(1, 9);
               default: ;
            endcase
            en = model(op, a, b);
            do_vec($sformatf("rnd%0d op%0d", i, op), op, a, b,
                   en, m_hi, m_lo);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
